// File: rtl/lsu_wait_ctrl.sv
// rtl/lsu_wait_ctrl.sv - memory-stage load/store unit with req/ack wait states and lane steering
// Optional macro LSU_TIMEOUT_EN: abort an unacknowledged access after TIMEOUT cycles and pulse fault_o.
module lsu_wait_ctrl #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_mask,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                stall_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                done_o,
    output logic                misalign_o,
    output logic                fault_o
);
    localparam int BPW   = XLEN / 8;
    localparam int OFF_W = $clog2(BPW);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state;

    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] align_mask;
    logic [1:0]       size;
    logic [1:0]       r_size;
    logic             r_uns;
    logic             req_go;
    logic             misalign;
    logic [BPW-1:0]   base_mask;
    logic [BPW-1:0]   lane_mask;
    logic [XLEN-1:0]  lane_wdata;
    logic [XLEN-1:0]  rd_shift;
    logic [XLEN-1:0]  keep;
    logic             sign_bit;
    logic [XLEN-1:0]  ld_ext;

    assign off    = addr[OFF_W-1:0];
    assign size   = funct3[1:0];
    assign req_go = req_valid & (is_load | is_store);

    // Address request path: alignment check and lane placement of store data
    always_comb begin
        align_mask = OFF_W'((4'd1 << size) - 4'd1);
        misalign   = (|(off & align_mask)) | ((size == 2'b11) && (XLEN == 32));
        case (size)
            2'b00:   base_mask = BPW'(1);
            2'b01:   base_mask = BPW'(3);
            2'b10:   base_mask = BPW'(15);
            default: base_mask = '1;
        endcase
        lane_mask  = base_mask << off;
        lane_wdata = wdata_i << {off, 3'b000};
    end

    // Load return path: right-align the lane, then sign- or zero-fill above it
    always_comb begin
        rd_shift = mem_rdata >> {r_off, 3'b000};
        case (r_size)
            2'b00:   begin keep = XLEN'(64'hFF);        sign_bit = rd_shift[7];  end
            2'b01:   begin keep = XLEN'(64'hFFFF);      sign_bit = rd_shift[15]; end
            2'b10:   begin keep = XLEN'(64'hFFFF_FFFF); sign_bit = rd_shift[31]; end
            default: begin keep = '1;                   sign_bit = 1'b0;         end
        endcase
        ld_ext = (rd_shift & keep) | ({XLEN{~r_uns & sign_bit}} & ~keep);
    end

    // The pipeline advances on the ack edge, so stall drops in the ack cycle itself
    assign stall_o = (state == ACCESS) ? ~mem_ack : (req_go & ~misalign);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign fault_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            rdata_o    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            r_off      <= '0;
            r_size     <= '0;
            r_uns      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= '0;
            fault_o    <= 1'b0;
`endif
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            fault_o    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_go) begin
                        if (misalign) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_mask  <= lane_mask;
                            mem_wdata <= lane_wdata;
                            r_off     <= off;
                            r_size    <= size;
                            r_uns     <= funct3[2];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done_o  <= 1'b1;
                        if (!mem_we) begin
                            rdata_o <= ld_ext;
                        end
`ifdef LSU_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This edge is the one on which the count would reach TIMEOUT
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        fault_o  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_wait_ctrl.sv
// tb/tb_lsu_wait_ctrl.sv - randomized self-checking bench driving 32- and 64-bit lsu_wait_ctrl side by side
module tb_lsu_wait_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, is_load, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata, mem_rdata;

    logic        req_a, we_a, stall_a, done_a, mis_a, fault_a;
    logic [31:0] addr_a, wdata_a, rd_a;
    logic [3:0]  mask_a;
    logic        req_b, we_b, stall_b, done_b, mis_b, fault_b;
    logic [31:0] addr_b;
    logic [63:0] wdata_b, rd_b;
    logic [7:0]  mask_b;

    lsu_wait_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata_i(wdata[31:0]), .mem_req(req_a), .mem_we(we_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_mask(mask_a), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata[31:0]), .stall_o(stall_a), .rdata_o(rd_a), .done_o(done_a),
        .misalign_o(mis_a), .fault_o(fault_a));

    lsu_wait_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata_i(wdata), .mem_req(req_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_mask(mask_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_o(stall_b), .rdata_o(rd_b), .done_o(done_b),
        .misalign_o(mis_b), .fault_o(fault_b));

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] exp_rd_a, exp_rd_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] xmask(input int xl);
        return (xl == 32) ? 64'hFFFF_FFFF : '1;
    endfunction

    function automatic bit misal(input int xl, input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % (xl / 8));
        int n = 1 << f3[1:0];
        return ((off % n) != 0) || (f3[1:0] == 2'b11 && xl == 32);
    endfunction

    function automatic logic [63:0] emask(input int xl, input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % (xl / 8));
        int n = 1 << f3[1:0];
        return 64'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [63:0] ewdata(input int xl, input logic [31:0] a, input logic [63:0] wd);
        int off = int'(a % (xl / 8));
        return ((wd & xmask(xl)) << (8 * off)) & xmask(xl);
    endfunction

    function automatic logic [63:0] ext(input int xl, input logic [2:0] f3, input logic [31:0] a,
                                        input logic [63:0] rd);
        int off = int'(a % (xl / 8));
        int n = 1 << f3[1:0];
        logic [63:0] lane, lm;
        lane = (rd & xmask(xl)) >> (8 * off);
        if (n < 8) begin
            lm = (64'd1 << (8 * n)) - 64'd1;
            lane = lane & lm;
            if (!f3[2] && (((lane >> (8 * n - 1)) & 64'd1) != 0)) lane = lane | ~lm;
        end
        return lane & xmask(xl);
    endfunction

    // One complete transaction starting at a negedge with both units idle or in their done cycle
    task automatic xact(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [63:0] wd, input logic [63:0] rd, input int waits);
        bit act, go_a, go_b;
        act  = ld | st;
        go_a = act && !misal(32, f3, a);
        go_b = act && !misal(64, f3, a);
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
        #1;
        check("stall_req_a", 64'(stall_a), 64'(go_a));
        check("stall_req_b", 64'(stall_b), 64'(go_b));
        @(negedge clk);
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
        check("misalign_a", 64'(mis_a), 64'(act && !go_a));
        check("misalign_b", 64'(mis_b), 64'(act && !go_b));
        check("req_a", 64'(req_a), 64'(go_a));
        check("req_b", 64'(req_b), 64'(go_b));
        if (go_a) begin
            check("addr_a", 64'(addr_a), 64'(a & ~32'h3));
            check("mask_a", 64'(mask_a), emask(32, f3, a));
            check("we_a", 64'(we_a), 64'(st));
            check("wdata_a", 64'(wdata_a), ewdata(32, a, wd));
        end
        if (go_b) begin
            check("addr_b", 64'(addr_b), 64'(a & ~32'h7));
            check("mask_b", 64'(mask_b), emask(64, f3, a));
            check("we_b", 64'(we_b), 64'(st));
            check("wdata_b", wdata_b, ewdata(64, a, wd));
        end
        if (go_a || go_b) begin
            for (int w = 0; w < waits; w++) begin
                mem_rdata = {$urandom, $urandom};
                #1;
                check("stall_wait_a", 64'(stall_a), 64'(go_a));
                check("stall_wait_b", 64'(stall_b), 64'(go_b));
                @(negedge clk);
                check("hold_req_a", 64'(req_a), 64'(go_a));
                check("hold_req_b", 64'(req_b), 64'(go_b));
                check("fault_wait_a", 64'(fault_a), 64'd0);
                check("fault_wait_b", 64'(fault_b), 64'd0);
                if (go_b) check("hold_mask_b", 64'(mask_b), emask(64, f3, a));
            end
            mem_ack = 1'b1; mem_rdata = rd;
            #1;
            check("stall_ack_a", 64'(stall_a), 64'd0);
            check("stall_ack_b", 64'(stall_b), 64'd0);
            @(negedge clk);
            mem_ack = 1'b0;
            if (go_a && ld) exp_rd_a = ext(32, f3, a, rd);
            if (go_b && ld) exp_rd_b = ext(64, f3, a, rd);
            check("done_a", 64'(done_a), 64'(go_a));
            check("done_b", 64'(done_b), 64'(go_b));
            check("req_done_a", 64'(req_a), 64'd0);
            check("req_done_b", 64'(req_b), 64'd0);
            check("we_done_b", 64'(we_b), 64'd0);
            check("rdata_a", 64'(rd_a), exp_rd_a);
            check("rdata_b", rd_b, exp_rd_b);
            check("fault_done_a", 64'(fault_a), 64'd0);
            check("misalign_done_a", 64'(mis_a), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            @(negedge clk);
            check("idle_done_a", 64'(done_a), 64'd0);
            check("idle_done_b", 64'(done_b), 64'd0);
            check("idle_mis_a", 64'(mis_a), 64'd0);
            check("idle_mis_b", 64'(mis_b), 64'd0);
            check("idle_req_a", 64'(req_a), 64'd0);
            check("idle_req_b", 64'(req_b), 64'd0);
            check("idle_fault_b", 64'(fault_b), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        exp_rd_a = '0; exp_rd_b = '0;
        repeat (2) @(negedge clk);
        check("rst_req_a", 64'(req_a), 64'd0);     check("rst_req_b", 64'(req_b), 64'd0);
        check("rst_we_a", 64'(we_a), 64'd0);       check("rst_addr_b", 64'(addr_b), 64'd0);
        check("rst_wdata_b", wdata_b, 64'd0);      check("rst_mask_a", 64'(mask_a), 64'd0);
        check("rst_stall_a", 64'(stall_a), 64'd0); check("rst_rdata_b", rd_b, 64'd0);
        check("rst_done_a", 64'(done_a), 64'd0);   check("rst_mis_b", 64'(mis_b), 64'd0);
        check("rst_fault_a", 64'(fault_a), 64'd0); check("rst_fault_b", 64'(fault_b), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        xact(1'b1, 1'b0, 3'b000, 32'h1003, 64'd0, 64'h80FF_FF7F, 3);
        check("tp_lb_rdata_a", 64'(rd_a), 64'hFFFF_FF80);
        idle(1);
        xact(1'b0, 1'b1, 3'b001, 32'h2002, 64'h0000_ABCD, 64'd0, 0);
        check("tp_sh_rdata_a", 64'(rd_a), 64'hFFFF_FF80);
        idle(1);
        xact(1'b1, 1'b0, 3'b010, 32'h0006, 64'd0, 64'd0, 0);
        idle(1);
        xact(1'b1, 1'b0, 3'b011, 32'h0008, 64'd0, 64'h1122_3344_5566_7788, 1);
        idle(1);
        xact(1'b1, 1'b0, 3'b110, 32'h0004, 64'd0, 64'h8765_4321_0000_0000, 1);
        check("tp_lwu_rdata_b", rd_b, 64'h0000_0000_8765_4321);
        idle(1);
        xact(1'b0, 1'b0, 3'b010, 32'h0000, 64'd0, 64'd0, 0);
        idle(1);
        xact(1'b1, 1'b0, 3'b101, 32'h0102, 64'd0, 64'hFFFF_FFFF_8001_0000, 0);
        xact(1'b0, 1'b1, 3'b000, 32'h0105, 64'hA5, 64'd0, 2);
        xact(1'b1, 1'b0, 3'b001, 32'h0106, 64'd0, 64'h9ABC_0000_8000_0000, 0);
        idle(1);

        // Reset two cycles into an access
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_req_a", 64'(req_a), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_rd_a = '0; exp_rd_b = '0;
        check("rstmid_drop_a", 64'(req_a), 64'd0);
        check("rstmid_drop_b", 64'(req_b), 64'd0);
        check("rstmid_stall_a", 64'(stall_a), 64'd0);
        mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_done_a", 64'(done_a), 64'd0);
        check("rstmid_done_b", 64'(done_b), 64'd0);
        check("rstmid_req_after", 64'(req_a), 64'd0);
        xact(1'b1, 1'b0, 3'b010, 32'h0048, 64'd0, 64'h0BAD_F00D_7654_3210, 1);
        idle(1);

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            #1;
            check("to_stall_a", 64'(stall_a), 64'd1);
            check("to_nofault_a", 64'(fault_a), 64'd0);
            @(negedge clk);
        end
        check("to_fault_a", 64'(fault_a), 64'd1);
        check("to_fault_b", 64'(fault_b), 64'd1);
        check("to_req_a", 64'(req_a), 64'd0);
        check("to_done_a", 64'(done_a), 64'd0);
        check("to_stall_fault_a", 64'(stall_a), 64'd0);
        idle(1);
        xact(1'b1, 1'b0, 3'b010, 32'h0024, 64'd0, 64'h0000_1234_CAFE_0001, 14);
        idle(1);
`else
        xact(1'b1, 1'b0, 3'b010, 32'h0024, 64'd0, 64'h0000_1234_CAFE_0001, 20);
        idle(1);
`endif

        for (int k = 0; k < 300; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            xact(op < 5, op >= 5 && op < 9, 3'($urandom), $urandom, {$urandom, $urandom},
                 {$urandom, $urandom}, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
